seven_seg_scan: RTL and testbench

Time-multiplexed driver for an N-digit common-segment 7-segment display. It holds a hex value of 4*DIGITS bits and scans one digit at a time. Each digit's nibble is decoded to segments, with a per-digit decimal point and optional leading-zero blanking. A guard interval prevents ghosting between digits. It sits between a status/count register and the board display pins, and replaces per-digit static decoders.

---
 rtl/seven_seg_scan_pkg.sv | 19 +
 rtl/seven_seg.sv | 14 +
 rtl/seven_seg_scan.sv | 159 +++++++++++++++
 tb/tb_seven_seg_scan.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// The segment table is in abcdefg order, with segment a as the MSB and active-high.
package seven_seg_scan_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef enum logic {
    DARK = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seven_seg.sv
// Combinational hex-to-segment decoder (abcdefg, a = MSB).
// INVERT selects active-low segment outputs.
module seven_seg
  import seven_seg_scan_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble] ^ {7{INVERT}};

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit 7-segment scanner with a guard interval, leading-zero blanking and frame-synchronous updates.
// All outputs are registered one cycle behind the prescaler/digit state; polarity is applied after the register.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int CLK_DIV       = 1000,
  parameter int GUARD         = 2,
  parameter bit SEG_INVERT    = 1'b0,
  parameter bit DIG_INVERT    = 1'b0,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  seg_a,
  output logic                  seg_b,
  output logic                  seg_c,
  output logic                  seg_d,
  output logic                  seg_e,
  output logic                  seg_f,
  output logic                  seg_g,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(CLK_DIV - 1);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seven_seg_scan: DIGITS must be 1..8");
  end

  scan_state_t          state;
  logic [PW-1:0]        presc;
  logic [DW-1:0]        digit;
  logic [4*DIGITS-1:0]  pend_val;
  logic [4*DIGITS-1:0]  act_val;
  logic [DIGITS-1:0]    pend_dp;
  logic [DIGITS-1:0]    act_dp;

  logic [6:0]           seg_q;
  logic                 dp_q;
  logic [DIGITS-1:0]    dig_q;
  logic                 frame_q;

  logic                 in_guard;
  logic [DIGITS-1:0]    blank;
  logic [DIGITS-1:0]    cur_sel;
  logic [3:0]           cur_nib;
  logic                 cur_dp;
  logic                 cur_blank;
  logic [6:0]           dec_seg;

  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (presc < PW'(GUARD));
  end

  // Walk from the top digit down; once a non-zero nibble or a dp is seen, nothing below is blank.
  always_comb begin
    logic keep;
    keep  = 1'b0;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      keep     = keep | (act_val[4*k +: 4] != 4'h0) | act_dp[k];
      blank[k] = BLANK_LEADING && (k != 0) && !keep;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sel   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit == DW'(k)) begin
        cur_nib    = act_val[4*k +: 4];
        cur_dp     = act_dp[k];
        cur_blank  = blank[k];
        cur_sel[k] = 1'b1;
      end
    end
  end

  seven_seg #(.INVERT(1'b0)) u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DARK;
      presc    <= '0;
      digit    <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      act_val  <= '0;
      act_dp   <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      dig_q    <= '0;
      frame_q  <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end

      seg_q   <= '0;
      dp_q    <= 1'b0;
      dig_q   <= '0;
      frame_q <= 1'b0;

      if (!enable) begin
        state <= DARK;
        presc <= '0;
        digit <= '0;
      end else if (state == DARK) begin
        state   <= SCAN;
        presc   <= '0;
        digit   <= '0;
        act_val <= load ? value : pend_val;
        act_dp  <= load ? dp_in : pend_dp;
      end else begin
        dig_q <= in_guard ? '0 : cur_sel;
        seg_q <= (in_guard || cur_blank) ? 7'h00 : dec_seg;
        dp_q  <= !in_guard && cur_dp;
        if (presc == LAST_PRE) begin
          presc <= '0;
          if (digit == LAST_DIG) begin
            // Frame boundary: a load on this very edge bypasses pending.
            digit   <= '0;
            frame_q <= 1'b1;
            act_val <= load ? value : pend_val;
            act_dp  <= load ? dp_in : pend_dp;
          end else begin
            digit <= digit + DW'(1);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_q ^ {7{SEG_INVERT}};
  assign seg_dp     = dp_q ^ SEG_INVERT;
  assign digit_en   = dig_q ^ {DIGITS{DIG_INVERT}};
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (active-high with a guard, active-low without one) checked each cycle against a reference model.
module tb_seven_seg_scan;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       fd;
  } obs_t;

  localparam logic [6:0] PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  localparam int CD  [2] = '{4, 3};
  localparam int GD  [2] = '{1, 0};
  localparam bit INV [2] = '{1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;

  logic [6:0] s0, s1;
  logic       dp0, dp1, fd0, fd1;
  logic [3:0] de0, de1;

  always #5 clk = ~clk;

  seven_seg_scan #(.DIGITS(4), .CLK_DIV(4), .GUARD(1), .SEG_INVERT(1'b0),
                   .DIG_INVERT(1'b0), .BLANK_LEADING(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .seg_a(s0[6]), .seg_b(s0[5]), .seg_c(s0[4]), .seg_d(s0[3]), .seg_e(s0[2]),
    .seg_f(s0[1]), .seg_g(s0[0]), .seg_dp(dp0), .digit_en(de0), .frame_done(fd0)
  );

  seven_seg_scan #(.DIGITS(4), .CLK_DIV(3), .GUARD(0), .SEG_INVERT(1'b1),
                   .DIG_INVERT(1'b1), .BLANK_LEADING(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .seg_a(s1[6]), .seg_b(s1[5]), .seg_c(s1[4]), .seg_d(s1[3]), .seg_e(s1[2]),
    .seg_f(s1[1]), .seg_g(s1[0]), .seg_dp(dp1), .digit_en(de1), .frame_done(fd1)
  );

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  obs_t exp_q[$];
  obs_t cur[2];

  bit          m_scan[2];
  int          m_pre[2];
  int          m_dig[2];
  logic [15:0] m_pend[2];
  logic [15:0] m_act[2];
  logic [3:0]  m_pdp[2];
  logic [3:0]  m_adp[2];

  bit         mon = 1'b0;
  logic [6:0] seen_seg[4];
  logic       seen_dp[4];
  int         en_cnt[4];
  int         fd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample(input int i);
    if (i == 0) return {s0, dp0, de0, fd0};
    return {s1, dp1, de1, fd1};
  endfunction

  function automatic obs_t inactive(input int i);
    return {INV[i] ? 7'h7F : 7'h00, INV[i], INV[i] ? 4'hF : 4'h0, 1'b0};
  endfunction

  task automatic model_reset(input int i);
    m_scan[i] = 1'b0; m_pre[i] = 0; m_dig[i] = 0;
    m_pend[i] = '0; m_act[i] = '0; m_pdp[i] = '0; m_adp[i] = '0;
  endtask

  // Expected outputs after this edge, then the state update the edge performs.
  task automatic model_edge(input int i);
    obs_t       o;
    logic [3:0] nib;
    bit         lead_zero;
    o = '0;
    if (enable && m_scan[i]) begin
      if (m_pre[i] >= GD[i]) begin
        nib       = 4'(m_act[i] >> (4 * m_dig[i]));
        lead_zero = (m_dig[i] > 0) && ((m_act[i] >> (4 * m_dig[i])) == 0)
                    && ((m_adp[i] >> m_dig[i]) == 0);
        o.dig = 4'(1 << m_dig[i]);
        o.dp  = m_adp[i][m_dig[i]];
        o.seg = lead_zero ? 7'h00 : PAT[nib];
      end
      o.fd = (m_pre[i] == CD[i] - 1) && (m_dig[i] == 3);
    end
    o.seg = o.seg ^ {7{INV[i]}};
    o.dp  = o.dp ^ INV[i];
    o.dig = o.dig ^ {4{INV[i]}};
    exp_q.push_back(o);

    if (!enable) begin
      m_scan[i] = 1'b0; m_pre[i] = 0; m_dig[i] = 0;
    end else if (!m_scan[i]) begin
      m_scan[i] = 1'b1; m_pre[i] = 0; m_dig[i] = 0;
      m_act[i] = load ? value : m_pend[i];
      m_adp[i] = load ? dp_in : m_pdp[i];
    end else if (m_pre[i] == CD[i] - 1) begin
      m_pre[i] = 0;
      if (m_dig[i] == 3) begin
        m_dig[i] = 0;
        m_act[i] = load ? value : m_pend[i];
        m_adp[i] = load ? dp_in : m_pdp[i];
      end else begin
        m_dig[i]++;
      end
    end else begin
      m_pre[i]++;
    end
    if (load) begin
      m_pend[i] = value;
      m_pdp[i]  = dp_in;
    end
  endtask

  task automatic tick();
    obs_t e;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        model_reset(i);
        exp_q.push_back(inactive(i));
      end else begin
        model_edge(i);
      end
    end
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      cur[i] = sample(i);
      e = exp_q.pop_front();
      check($sformatf("cyc%0d_dut%0d", cyc, i), cur[i], e);
    end
    if (cur[0].fd) fd_q.push_back(cyc);
    if (mon) begin
      for (int d = 0; d < 4; d++) begin
        if (cur[0].dig == (4'b0001 << d)) begin
          seen_seg[d] = cur[0].seg;
          seen_dp[d]  = cur[0].dp;
          en_cnt[d]++;
        end
      end
    end
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 4; d++) begin
      seen_seg[d] = 7'h55;
      seen_dp[d]  = 1'b0;
      en_cnt[d]   = 0;
    end
  endtask

  task automatic wait_en0(input logic [3:0] pat, input string tag);
    int n;
    n = 0;
    while (cur[0].dig !== pat && n < 100) begin
      tick();
      n++;
    end
    check(tag, cur[0].dig, pat);
  endtask

  task automatic start_latency(input string tag);
    int n;
    n = 0;
    while (cur[0].dig !== 4'b0001 && n < 20) begin
      tick();
      n++;
    end
    check(tag, n, 2);
  endtask

  // Advance until the model says the next edge is the frame boundary of dut0.
  task automatic to_boundary();
    int n;
    n = 0;
    while (!(m_scan[0] && m_pre[0] == 3 && m_dig[0] == 3) && n < 100) begin
      tick();
      n++;
    end
    check("boundary_timeout", n >= 100, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int tear_bad;
    #1 rst_n = 1'b0;
    #1;
    cur[0] = sample(0);
    cur[1] = sample(1);
    check("rst_dig0", de0, 4'h0);
    check("rst_seg0", {s0, dp0}, 8'h00);
    check("rst_fd0", fd0, 1'b0);
    check("rst_dig1", de1, 4'hF);
    check("rst_seg1", {s1, dp1}, 8'hFF);
    for (int i = 0; i < 2; i++) model_reset(i);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("dark_pol1", cur[1], {7'h7F, 1'b1, 4'hF, 1'b0});

    // Scan order and slot timing with 12AF.
    value = 16'h12AF; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1;
    tick();
    start_latency("start_lat");
    clear_mon(); fd_q.delete(); mon = 1'b1;
    repeat (32) tick();
    mon = 1'b0;
    for (int d = 0; d < 4; d++) check($sformatf("en_cnt%0d", d), en_cnt[d], 6);
    check("seg_d0_F", seen_seg[0], 7'b1000111);
    check("seg_d1_A", seen_seg[1], 7'b1110111);
    check("seg_d2_2", seen_seg[2], 7'b1101101);
    check("seg_d3_1", seen_seg[3], 7'b0110000);
    check("fd_count", fd_q.size(), 2);
    if (fd_q.size() >= 2) check("fd_period", fd_q[1] - fd_q[0], 16);

    // Leading-zero blanking, then dp stopping the blank.
    value = 16'h0040; dp_in = 4'b0000; load = 1'b1; tick(); load = 1'b0;
    repeat (36) tick();
    clear_mon(); mon = 1'b1; repeat (16) tick(); mon = 1'b0;
    check("blank_d3", seen_seg[3], 7'h00);
    check("blank_d2", seen_seg[2], 7'h00);
    check("blank_d1", seen_seg[1], 7'b0110011);
    check("blank_d0", seen_seg[0], 7'b1111110);
    dp_in = 4'b0100; load = 1'b1; tick(); load = 1'b0;
    repeat (36) tick();
    clear_mon(); mon = 1'b1; repeat (16) tick(); mon = 1'b0;
    check("dp_d2_seg", seen_seg[2], 7'b1111110);
    check("dp_d2_dp", seen_dp[2], 1'b1);
    check("dp_d3_blank", seen_seg[3], 7'h00);
    check("dp_d3_dp", seen_dp[3], 1'b0);
    dp_in = 4'b0000;

    // Mid-frame load must not tear the current frame.
    value = 16'h2222; load = 1'b1; tick(); load = 1'b0;
    to_boundary();
    tick();
    repeat (6) tick();
    value = 16'h1111; load = 1'b1; tick(); load = 1'b0;
    tear_bad = 0;
    for (int n = 0; n < 40 && !cur[0].fd; n++) begin
      tick();
      if (cur[0].dig != 4'h0 && cur[0].seg != 7'b1101101) tear_bad++;
    end
    check("tear_hold", tear_bad, 0);
    check("tear_fd", cur[0].fd, 1'b1);
    wait_en0(4'b0001, "tear_next_wait");
    check("tear_next_seg", cur[0].seg, 7'b0110000);

    // Load on the boundary edge itself shows in the very next frame.
    to_boundary();
    value = 16'h3333; load = 1'b1; tick(); load = 1'b0;
    wait_en0(4'b0001, "coin_wait");
    check("coin_seg", cur[0].seg, 7'b1111001);

    // Enable dropped mid digit 2, restart at digit 0 with latest pending.
    wait_en0(4'b0100, "toggle_wait");
    value = 16'h5555; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("toggle_dark_dig", cur[0].dig, 4'h0);
      check("toggle_dark_seg", cur[0].seg, 7'h00);
    end
    enable = 1'b1;
    tick();
    start_latency("reen_lat");
    check("reen_seg", cur[0].seg, 7'b1011011);

    // Asynchronous reset while digit 2 is lit.
    wait_en0(4'b0100, "rst_wait");
    #3 rst_n = 1'b0;
    #1;
    check("arst_dig0", de0, 4'h0);
    check("arst_seg0", {s0, dp0}, 8'h00);
    check("arst_fd0", fd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    start_latency("arst_lat");

    // Inverted polarity: digit 0 showing 8 drives every segment low.
    value = 16'h0008; load = 1'b1; tick(); load = 1'b0;
    repeat (20) tick();
    for (int n = 0; n < 50 && cur[1].dig !== 4'b1110; n++) tick();
    check("pol_dig1", cur[1].dig, 4'b1110);
    check("pol_seg8", cur[1].seg, 7'h00);
    check("pol_dp", cur[1].dp, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
